// File: rtl/stream_mux_rr.sv
// stream_mux_rr: N-channel packet multiplexer with valid/ready handshakes.
// Each packet gets one input channel. The channel is chosen in IDLE, either
// round-robin or from an external select, and is held until the packet's
// last beat is accepted. Beats pass through one output register stage.
//
// Handshake rules on every valid/ready pair of this block: a beat transfers
// on a rising clock edge where valid and ready are both 1. A producer holds
// valid and its payload stable until that edge. A consumer may raise or drop
// ready at any time. Here in_ready is derived only from registered state and
// out_ready, never from in_valid, so no combinational loop can form through
// a producer that waits for ready before raising valid.
//
// FSM visibility: the current state is held in the enum signal 'state_q'
// (ST_IDLE / ST_LOCKED). Checkers may bind to it together with grant_q and
// rr_ptr_q.

module stream_mux_rr #(
  parameter  int WIDTH    = 4,
  parameter  int CHANNELS = 4,
  localparam int SEL_W    = $clog2(CHANNELS)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
  input  logic [CHANNELS-1:0]       in_valid,
  input  logic [CHANNELS-1:0]       in_last,
  output logic [CHANNELS-1:0]       in_ready,
  input  logic [SEL_W-1:0]          sel,
  input  logic                      rr_en,
  output logic [WIDTH-1:0]          out_data,
  output logic                      out_valid,
  output logic                      out_last,
  output logic [SEL_W-1:0]          out_chan,
  input  logic                      out_ready
);

  // IDLE: arbitrate, no beat moves. LOCKED: forward beats of the granted
  // channel until its last beat is accepted.
  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } state_t;

  state_t           state_q;
  state_t           state_d;
  logic [SEL_W-1:0] grant_q;
  logic [SEL_W-1:0] grant_d;
  logic [SEL_W-1:0] rr_ptr_q;
  logic [SEL_W-1:0] rr_ptr_d;

  // Arbitration result for the current IDLE cycle.
  logic             pick_valid;
  logic [SEL_W-1:0] pick_idx;

  // Beat offered by the granted channel.
  logic [WIDTH-1:0] g_data;
  logic             g_valid;
  logic             g_last;

  // The output register can take a new beat when it is empty or being drained.
  logic             can_take;
  logic             accept;

  // Pick the channel a new packet would come from, depending on mode.
  always_comb begin
    pick_valid = 1'b0;
    pick_idx   = '0;
    if (rr_en) begin
      // Walk offsets from farthest to nearest so the nearest requester after
      // rr_ptr overwrites the others and wins.
      for (int i = CHANNELS; i >= 1; i--) begin
        if (in_valid[(int'(rr_ptr_q) + i) % CHANNELS]) begin
          pick_valid = 1'b1;
          pick_idx   = SEL_W'((int'(rr_ptr_q) + i) % CHANNELS);
        end
      end
    end else begin
      // Only an in-range select can match a channel, so sel >= CHANNELS
      // never produces a grant.
      for (int c = 0; c < CHANNELS; c++) begin
        if ((sel == SEL_W'(c)) && in_valid[c]) begin
          pick_valid = 1'b1;
          pick_idx   = SEL_W'(c);
        end
      end
    end
  end

  // Route the granted channel's beat to a single set of signals.
  always_comb begin
    g_data  = '0;
    g_valid = 1'b0;
    g_last  = 1'b0;
    for (int c = 0; c < CHANNELS; c++) begin
      if (grant_q == SEL_W'(c)) begin
        g_data  = in_data[c*WIDTH +: WIDTH];
        g_valid = in_valid[c];
        g_last  = in_last[c];
      end
    end
  end

  assign can_take = !out_valid || out_ready;
  assign accept   = (state_q == ST_LOCKED) && g_valid && can_take;

  // State, grant and round-robin pointer registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      grant_q  <= '0;
      rr_ptr_q <= SEL_W'(CHANNELS - 1);
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

  // Next state: lock onto a pick in IDLE, release after the last beat.
  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    rr_ptr_d = rr_ptr_q;
    case (state_q)
      ST_IDLE: begin
        if (pick_valid) begin
          grant_d = pick_idx;
          state_d = ST_LOCKED;
        end
      end
      ST_LOCKED: begin
        if (accept && g_last) begin
          rr_ptr_d = grant_q;
          state_d  = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Ready goes only to the granted channel, and only while LOCKED.
  always_comb begin
    in_ready = '0;
    if (state_q == ST_LOCKED) begin
      in_ready[grant_q] = can_take;
    end
  end

  // Output register: load on accept, empty when drained, hold otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
      out_chan  <= '0;
    end else if (accept) begin
      out_valid <= 1'b1;
      out_data  <= g_data;
      out_last  <= g_last;
      out_chan  <= grant_q;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_stream_mux_rr.sv
// tb_stream_mux_rr: bench for stream_mux_rr. Producers are per-channel beat
// queues; the expected output order comes from a packet-level arbitration
// model working on its own copy of the queued packets.

module tb_stream_mux_rr;

  localparam int W  = 4;
  localparam int CH = 4;
  localparam int SW = 2;
  localparam int BW = SW + 1 + W;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst_n;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- main DUT (4 channels) ----------------
  logic [CH*W-1:0] in_data;
  logic [CH-1:0]   in_valid;
  logic [CH-1:0]   in_last;
  logic [CH-1:0]   in_ready;
  logic [SW-1:0]   sel;
  logic            rr_en;
  logic [W-1:0]    out_data;
  logic            out_valid;
  logic            out_last;
  logic [SW-1:0]   out_chan;
  logic            out_ready;

  stream_mux_rr #(.WIDTH(W), .CHANNELS(CH)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_data(in_data), .in_valid(in_valid), .in_last(in_last),
    .in_ready(in_ready), .sel(sel), .rr_en(rr_en),
    .out_data(out_data), .out_valid(out_valid), .out_last(out_last),
    .out_chan(out_chan), .out_ready(out_ready)
  );

  // ---------------- second DUT (3 channels, unused select code) ----------------
  logic [3*W-1:0] in_data3;
  logic [2:0]     in_valid3;
  logic [2:0]     in_last3;
  logic [2:0]     in_ready3;
  logic [1:0]     sel3;
  logic           rr_en3;
  logic [W-1:0]   out_data3;
  logic           out_valid3;
  logic           out_last3;
  logic [1:0]     out_chan3;
  logic           out_ready3;

  stream_mux_rr #(.WIDTH(W), .CHANNELS(3)) dut3 (
    .clk(clk), .rst_n(rst_n),
    .in_data(in_data3), .in_valid(in_valid3), .in_last(in_last3),
    .in_ready(in_ready3), .sel(sel3), .rr_en(rr_en3),
    .out_data(out_data3), .out_valid(out_valid3), .out_last(out_last3),
    .out_chan(out_chan3), .out_ready(out_ready3)
  );

  // ---------------- bench state ----------------
  int vectors;
  int miscompares;

  logic [W:0]    src_q[CH][$];   // producer beats {last, data}
  logic [W:0]    mdl_q[CH][$];   // model copy of the same packets
  logic [BW-1:0] exp_q[$];       // expected output beats {chan, last, data}
  int            ptr_m;          // model round-robin pointer
  int            acc_last_cyc;   // cycle index of the last input accept
  logic [CH-1:0] rdy_seen;       // OR of in_ready over a run

  // ---------------- stimulus helpers ----------------
  task automatic load_beat(input int c, input logic [W-1:0] d, input logic l);
    src_q[c].push_back({l, d});
    mdl_q[c].push_back({l, d});
  endtask

  task automatic load_packet(input int c, input int len);
    for (int k = 0; k < len; k++) begin
      load_beat(c, W'($urandom_range(0, (1 << W) - 1)), (k == len - 1));
    end
  endtask

  task automatic clear_chan(input int c);
    src_q[c].delete();
    mdl_q[c].delete();
  endtask

  // ---------------- reference model ----------------
  // Move one whole packet of channel c to the expected stream.
  task automatic model_take_packet(input int c);
    logic [W:0] b;
    b = '0;
    while (mdl_q[c].size() > 0) begin
      b = mdl_q[c].pop_front();
      exp_q.push_back({SW'(c), b});
      if (b[W]) break;
    end
  endtask

  // Serve all pending packets round-robin: the next packet comes from the
  // first non-empty channel after the one that finished last.
  task automatic model_rr();
    bit found;
    do begin
      found = 0;
      for (int i = 1; i <= CH; i++) begin
        if (!found && mdl_q[(ptr_m + i) % CH].size() > 0) begin
          found = 1;
          ptr_m = (ptr_m + i) % CH;
          model_take_packet(ptr_m);
        end
      end
    end while (found);
  endtask

  // ---------------- traffic engine / scoreboard ----------------
  // Drives producers from src_q, consumes with out_ready, checks every
  // output beat against exp_q, output stability under backpressure and
  // ready legality. Optional: stall window, mid-run sel/rr_en change,
  // reset pulse at a given cycle (which ends the run).
  task automatic run_traffic(input int max_cyc, input int ready_pct,
                             input int stall_at, input int stall_len,
                             input int chg_at, input logic [SW-1:0] chg_sel,
                             input logic chg_rr, input int rst_at);
    int            cyc;
    logic [CH-1:0] hs_in;
    logic          hs_out;
    logic [BW-1:0] got;
    logic [BW-1:0] want;
    logic          held;
    logic [BW-1:0] held_beat;
    cyc = 0;
    held = 0;
    held_beat = '0;
    acc_last_cyc = -1;
    while (cyc < max_cyc) begin
      @(negedge clk);
      if (cyc == rst_at) begin
        rst_n = 1'b0;
        in_valid = '0;
        #1;
        vectors++;
        if ({out_valid, out_data, out_last, out_chan, in_ready} !== '0) begin
          miscompares++;
          $display("FAIL reset_mid_packet: got valid=%b data=%h last=%b chan=%0d rdy=%b, want all 0",
                   out_valid, out_data, out_last, out_chan, in_ready);
        end
        for (int c = 0; c < CH; c++) clear_chan(c);
        exp_q.delete();
        ptr_m = CH - 1;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        return;
      end
      if (cyc == chg_at) begin
        sel = chg_sel;
        rr_en = chg_rr;
      end
      if (cyc >= stall_at && cyc < stall_at + stall_len) out_ready = 1'b0;
      else out_ready = ($urandom_range(1, 100) <= ready_pct);
      for (int c = 0; c < CH; c++) begin
        if (src_q[c].size() > 0) begin
          in_valid[c] = 1'b1;
          {in_last[c], in_data[c*W +: W]} = src_q[c][0];
        end else begin
          in_valid[c] = 1'b0;
          in_last[c] = 1'($urandom_range(0, 1));
          in_data[c*W +: W] = W'($urandom_range(0, (1 << W) - 1));
        end
      end
      #1;
      if (held) begin
        vectors++;
        if (out_valid !== 1'b1 || {out_chan, out_last, out_data} !== held_beat) begin
          miscompares++;
          $display("FAIL hold_stable: got v=%b beat=%h, want v=1 beat=%h",
                   out_valid, {out_chan, out_last, out_data}, held_beat);
        end
      end
      if (out_valid && !out_ready) begin
        vectors++;
        if (in_ready !== '0) begin
          miscompares++;
          $display("FAIL ready_under_stall: got %b, want 0000", in_ready);
        end
      end
      if ((in_ready & (in_ready - 1'b1)) != '0) begin
        vectors++;
        miscompares++;
        $display("FAIL ready_onehot: got %b, want one-hot or zero", in_ready);
      end
      rdy_seen = rdy_seen | in_ready;
      hs_in = in_valid & in_ready;
      hs_out = out_valid && out_ready;
      got = {out_chan, out_last, out_data};
      held = out_valid && !out_ready;
      held_beat = got;
      @(posedge clk);
      for (int c = 0; c < CH; c++) begin
        if (hs_in[c] && src_q[c].size() > 0) begin
          void'(src_q[c].pop_front());
          acc_last_cyc = cyc;
        end
      end
      if (hs_out) begin
        vectors++;
        if (exp_q.size() == 0) begin
          miscompares++;
          $display("FAIL out_beat: got chan=%0d last=%b data=%h, want no beat",
                   got[BW-1 -: SW], got[W], got[W-1:0]);
        end else begin
          want = exp_q.pop_front();
          if (got !== want) begin
            miscompares++;
            $display("FAIL out_beat: got chan=%0d last=%b data=%h, want chan=%0d last=%b data=%h",
                     got[BW-1 -: SW], got[W], got[W-1:0],
                     want[BW-1 -: SW], want[W], want[W-1:0]);
          end
        end
      end
      cyc++;
      if (exp_q.size() == 0 && !held) break;
    end
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL traffic_timeout: got %0d beats still expected after %0d cycles, want 0",
               exp_q.size(), cyc);
      exp_q.delete();
    end
    // Drop producer valids before the DUT can re-arbitrate on stale beats.
    @(negedge clk);
    in_valid = '0;
    out_ready = 1'b1;
    #1;
    vectors++;
    if (out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL no_extra_beat: got out_valid=%b, want 0", out_valid);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    in_valid = '0;
    in_last = '0;
    in_data = '0;
    sel = '0;
    rr_en = 1'b1;
    out_ready = 1'b1;
    in_valid3 = '0;
    in_last3 = '0;
    in_data3 = '0;
    sel3 = '0;
    rr_en3 = 1'b0;
    out_ready3 = 1'b1;
    ptr_m = CH - 1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    vectors++;
    if ({out_valid, out_data, out_last, out_chan} !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs: got valid=%b data=%h last=%b chan=%0d, want all 0",
               out_valid, out_data, out_last, out_chan);
    end
    vectors++;
    if (in_ready !== '0) begin
      miscompares++;
      $display("FAIL reset_in_ready: got %b, want 0000", in_ready);
    end
  endtask

  // All four channels send a 2-beat packet at once in round-robin mode.
  task automatic test_rr_all();
    rr_en = 1'b1;
    for (int c = 0; c < CH; c++) load_packet(c, 2);
    model_rr();
    run_traffic(200, 100, -1, 0, -1, '0, 1'b1, -1);
    vectors++;
    if (acc_last_cyc + 1 != 2 * CH + CH) begin
      miscompares++;
      $display("FAIL rr_throughput: got %0d cycles, want %0d", acc_last_cyc + 1, 3 * CH);
    end
  endtask

  // Select-driven: ch2 is served, ch1 waits forever with valid high.
  task automatic test_sel_mode();
    rr_en = 1'b0;
    sel = 2'd2;
    rdy_seen = '0;
    load_beat(2, 4'hA, 1'b0);
    load_beat(2, 4'hB, 1'b1);
    load_packet(1, 3);
    model_take_packet(2);
    ptr_m = 2;
    run_traffic(200, 100, -1, 0, -1, '0, 1'b0, -1);
    vectors++;
    if (rdy_seen !== 4'b0100) begin
      miscompares++;
      $display("FAIL sel_ready_mask: got %b, want 0100", rdy_seen);
    end
    clear_chan(1);
  endtask

  // Consumer stalls three cycles in the middle of a packet.
  task automatic test_backpressure();
    rr_en = 1'b1;
    load_packet(3, 5);
    model_rr();
    run_traffic(200, 100, 3, 3, -1, '0, 1'b1, -1);
  endtask

  // sel and rr_en change while a ch1 packet is in flight.
  task automatic test_mode_change();
    rr_en = 1'b0;
    sel = 2'd1;
    load_packet(1, 4);
    load_packet(0, 2);
    load_packet(3, 2);
    model_take_packet(1);
    ptr_m = 1;
    model_rr();
    run_traffic(300, 100, -1, 0, 3, 2'd3, 1'b1, -1);
  endtask

  // Reset pulse during beat 2 of 4, then round-robin restarts at ch0.
  task automatic test_reset_mid();
    rr_en = 1'b1;
    load_packet(2, 4);
    model_rr();
    run_traffic(50, 100, -1, 0, -1, '0, 1'b1, 3);
    load_packet(2, 2);
    load_packet(3, 1);
    load_packet(0, 3);
    model_rr();
    vectors++;
    if (exp_q[0][BW-1 -: SW] !== 2'd0) begin
      miscompares++;
      $display("FAIL model_first_after_reset: got chan=%0d, want 0", exp_q[0][BW-1 -: SW]);
    end
    run_traffic(300, 100, -1, 0, -1, '0, 1'b1, -1);
  endtask

  // Random packets, random consumer readiness, both modes.
  task automatic test_random();
    int s;
    int o;
    for (int r = 0; r < 6; r++) begin
      rr_en = 1'b1;
      for (int c = 0; c < CH; c++) begin
        for (int p = $urandom_range(0, 3); p > 0; p--) load_packet(c, $urandom_range(1, 4));
      end
      model_rr();
      run_traffic(2000, $urandom_range(30, 100), -1, 0, -1, '0, 1'b1, -1);
    end
    for (int r = 0; r < 4; r++) begin
      s = $urandom_range(0, CH - 1);
      o = (s + $urandom_range(1, CH - 1)) % CH;
      rr_en = 1'b0;
      sel = SW'(s);
      for (int p = $urandom_range(1, 3); p > 0; p--) load_packet(s, $urandom_range(1, 4));
      load_packet(o, 2);
      while (mdl_q[s].size() > 0) model_take_packet(s);
      ptr_m = s;
      run_traffic(2000, $urandom_range(30, 100), -1, 0, -1, '0, 1'b0, -1);
      clear_chan(o);
    end
  endtask

  // 3-channel instance: sel=3 names no channel and must never grant.
  task automatic test_sel_out_of_range();
    rr_en3 = 1'b0;
    sel3 = 2'd3;
    in_valid3 = 3'b111;
    in_last3 = 3'b111;
    in_data3 = 12'h5A3;
    out_ready3 = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      #1;
      vectors++;
      if (in_ready3 !== 3'b000 || out_valid3 !== 1'b0) begin
        miscompares++;
        $display("FAIL sel_out_of_range: got rdy=%b v=%b, want rdy=000 v=0",
                 in_ready3, out_valid3);
      end
    end
    sel3 = 2'd2;
    @(negedge clk);
    #1;
    vectors++;
    if (in_ready3 !== 3'b100) begin
      miscompares++;
      $display("FAIL sel_in_range: got rdy=%b, want 100", in_ready3);
    end
    @(negedge clk);
    in_valid3 = '0;
    #1;
    vectors++;
    if (out_valid3 !== 1'b1 || out_chan3 !== 2'd2 || out_data3 !== 4'h5 || out_last3 !== 1'b1) begin
      miscompares++;
      $display("FAIL sel3_beat: got v=%b chan=%0d data=%h last=%b, want v=1 chan=2 data=5 last=1",
               out_valid3, out_chan3, out_data3, out_last3);
    end
    repeat (3) @(negedge clk);
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    vectors = 0;
    miscompares = 0;
    rdy_seen = '0;
    acc_last_cyc = -1;
    test_reset();
    test_rr_all();
    test_sel_mode();
    test_backpressure();
    test_mode_change();
    test_reset_mid();
    test_random();
    test_sel_out_of_range();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
